// File: rtl/fp32_mul_scheduler.sv
// ============================================================================
//  Module   : fp32_mul_scheduler
//  Function : round-robin sharing of one FP32 multiplier; issue-order,
//             credit-protected responses. Optional: FP_MUL_ZERO_BYPASS_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp32_mul_scheduler #(
  parameter int NUM_REQ   = 4,
  parameter int ID_W      = 2,
  parameter int MUL_LAT   = 1,
  parameter int RSP_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*32-1:0] req_a,
  input  logic [NUM_REQ*32-1:0] req_b,
  output logic [31:0]           mul_a,
  output logic [31:0]           mul_b,
  output logic                  mul_valid,
  input  logic [31:0]           mul_res,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [31:0]           rsp_data,
  output logic                  busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PTR_W = $clog2(RSP_DEPTH);
  localparam int CNT_W = $clog2(RSP_DEPTH + 1);

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [31:0]        mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic [MUL_LAT-1:0] tag_v_q, tag_v_d;
  logic [ID_W-1:0]    tag_id_q [MUL_LAT];
  logic [ID_W-1:0]    tag_id_d [MUL_LAT];
`ifdef FP_MUL_ZERO_BYPASS_EN
  logic [MUL_LAT-1:0] tag_z_q, tag_z_d, tag_s_q, tag_s_d;
`endif
  logic [ID_W-1:0]    fid_q [RSP_DEPTH];
  logic [ID_W-1:0]    fid_d [RSP_DEPTH];
  logic [31:0]        fdata_q [RSP_DEPTH];
  logic [31:0]        fdata_d [RSP_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   fcnt_q, fcnt_d;

  logic               gnt_found, grant, push, pop;
  logic [IDX_W-1:0]   gnt_idx;
  logic [31:0]        sel_a, sel_b, push_data;
  logic [ID_W-1:0]    push_id;
  int                 cand;

  // Search starts one past the last winner; credits use the registered count.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    sel_a     = '0;
    sel_b     = '0;
    cand      = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = int'(last_q) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = IDX_W'(cand);
        sel_a     = req_a[cand*32 +: 32];
        sel_b     = req_b[cand*32 +: 32];
      end
    end
    grant     = gnt_found && rst_n && (cnt_q < CNT_W'(RSP_DEPTH));
    req_ready = '0;
    if (grant) req_ready[gnt_idx] = 1'b1;
  end

  assign rsp_valid = (fcnt_q != '0);
  assign rsp_id    = fid_q[rd_ptr_q];
  assign rsp_data  = fdata_q[rd_ptr_q];
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign mul_valid = tag_v_q[0];
  assign busy      = (cnt_q != '0);

  always_comb begin
    last_d   = last_q;
    mul_a_d  = mul_a_q;
    mul_b_d  = mul_b_q;
    tag_v_d  = tag_v_q;
    tag_id_d = tag_id_q;
    if (grant) begin
      last_d  = gnt_idx;
      mul_a_d = sel_a;
      mul_b_d = sel_b;
    end
    tag_v_d[0]  = grant;
    tag_id_d[0] = ID_W'(gnt_idx);
    for (int s = 1; s < MUL_LAT; s++) begin
      tag_v_d[s]  = tag_v_q[s-1];
      tag_id_d[s] = tag_id_q[s-1];
    end

    push    = tag_v_q[MUL_LAT-1];
    push_id = tag_id_q[MUL_LAT-1];
`ifdef FP_MUL_ZERO_BYPASS_EN
    tag_z_d    = tag_z_q;
    tag_s_d    = tag_s_q;
    tag_z_d[0] = (sel_a[30:0] == 31'b0) || (sel_b[30:0] == 31'b0);
    tag_s_d[0] = sel_a[31] ^ sel_b[31];
    for (int s = 1; s < MUL_LAT; s++) begin
      tag_z_d[s] = tag_z_q[s-1];
      tag_s_d[s] = tag_s_q[s-1];
    end
    push_data = tag_z_q[MUL_LAT-1] ? {tag_s_q[MUL_LAT-1], 31'b0} : mul_res;
`else
    push_data = mul_res;
`endif

    pop      = rsp_valid && rsp_ready;
    fid_d    = fid_q;
    fdata_d  = fdata_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      fid_d[wr_ptr_q]   = push_id;
      fdata_d[wr_ptr_q] = push_data;
      wr_ptr_d = (wr_ptr_q == PTR_W'(RSP_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(RSP_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    end

    fcnt_d = fcnt_q;
    if (push && !pop)      fcnt_d = fcnt_q + CNT_W'(1);
    else if (!push && pop) fcnt_d = fcnt_q - CNT_W'(1);

    cnt_d = cnt_q;
    if (grant && !pop)      cnt_d = cnt_q + CNT_W'(1);
    else if (!grant && pop) cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      last_q   <= IDX_W'(NUM_REQ - 1);
      mul_a_q  <= '0;
      mul_b_q  <= '0;
      tag_v_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fcnt_q   <= '0;
      for (int s = 0; s < MUL_LAT; s++) tag_id_q[s] <= '0;
      for (int e = 0; e < RSP_DEPTH; e++) begin
        fid_q[e]   <= '0;
        fdata_q[e] <= '0;
      end
`ifdef FP_MUL_ZERO_BYPASS_EN
      tag_z_q <= '0;
      tag_s_q <= '0;
`endif
    end else begin
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      mul_a_q  <= mul_a_d;
      mul_b_q  <= mul_b_d;
      tag_v_q  <= tag_v_d;
      tag_id_q <= tag_id_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fcnt_q   <= fcnt_d;
      fid_q    <= fid_d;
      fdata_q  <= fdata_d;
`ifdef FP_MUL_ZERO_BYPASS_EN
      tag_z_q <= tag_z_d;
      tag_s_q <= tag_s_d;
`endif
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fp32_mul_scheduler.sv
// ============================================================================
//  Module   : tb_fp32_mul_scheduler
//  Function : randomized scoreboard bench for fp32_mul_scheduler
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fp32_mul_scheduler;

  localparam int NUM_REQ   = 4;
  localparam int ID_W      = 2;
  localparam int MUL_LAT   = 3;
  localparam int RSP_DEPTH = 4;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*32-1:0] req_a, req_b;
  logic [31:0]           mul_a, mul_b, mul_res;
  logic                  mul_valid;
  logic                  rsp_valid, rsp_ready;
  logic [ID_W-1:0]       rsp_id;
  logic [31:0]           rsp_data;
  logic                  busy;

  fp32_mul_scheduler #(
    .NUM_REQ(NUM_REQ), .ID_W(ID_W), .MUL_LAT(MUL_LAT), .RSP_DEPTH(RSP_DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .mul_a(mul_a), .mul_b(mul_b), .mul_valid(mul_valid), .mul_res(mul_res),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .busy(busy)
  );

  always #5 clk = ~clk;

  // Stand-in multiplier: two directed pairs give fixed answers, others a hash.
  function automatic logic [31:0] mul_model(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h4000_0000 && b == 32'h4040_0000) return 32'h40C0_0000;
    if (a == 32'h8000_0000 && b == 32'h3F80_0000) return 32'h1234_5678;
    return (a ^ {b[15:0], b[31:16]}) + 32'h9E37_79B9;
  endfunction

  function automatic logic [31:0] exp_result(input logic [31:0] a, input logic [31:0] b);
`ifdef FP_MUL_ZERO_BYPASS_EN
    if (a[30:0] == 31'b0 || b[30:0] == 31'b0) return {a[31] ^ b[31], 31'b0};
`endif
    return mul_model(a, b);
  endfunction

  generate
    if (MUL_LAT == 1) begin : g_mul_comb
      assign mul_res = mul_model(mul_a, mul_b);
    end else begin : g_mul_pipe
      logic [31:0] p [MUL_LAT-1];
      always @(posedge clk) begin
        p[0] <= mul_model(mul_a, mul_b);
        for (int i = 1; i < MUL_LAT - 1; i++) p[i] <= p[i-1];
      end
      assign mul_res = p[MUL_LAT-2];
    end
  endgenerate

  typedef struct {
    logic [ID_W-1:0] id;
    logic [31:0]     data;
    int              avail;
  } exp_t;

  exp_t               q[$];
  int                 n_cmp = 0;
  int                 n_bad = 0;
  int                 cyc = 0;
  logic               rst_at_edge = 1'b0;
  logic [NUM_REQ-1:0] hs_mask = '0;

  int                 outstanding = 0;
  int                 last = NUM_REQ - 1;
  logic               prev_hs = 1'b0;
  logic [31:0]        prev_a = '0, prev_b = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    cyc         <= cyc + 1;
    rst_at_edge <= !rst_n;
  end

  // Reference model and scoreboard: arbitration, credits and issue order.
  always @(negedge clk) begin
    logic [NUM_REQ-1:0] exp_ready;
    logic               found, exp_rv;
    int                 c, w;
    exp_t               e;
    if (!rst_n) begin
      q.delete();
      outstanding = 0;
      last        = NUM_REQ - 1;
      prev_hs     = 1'b0;
      hs_mask     = '0;
      chk("rst_req_ready", 32'(req_ready), 32'h0);
      if (rst_at_edge) begin
        chk("rst_mul_valid", 32'(mul_valid), 32'h0);
        chk("rst_mul_a", mul_a, 32'h0);
        chk("rst_mul_b", mul_b, 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_id", 32'(rsp_id), 32'h0);
        chk("rst_rsp_data", rsp_data, 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
      end
    end else begin
      found = 1'b0;
      w     = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
        c = (last + k) % NUM_REQ;
        if (!found && req_valid[c]) begin
          found = 1'b1;
          w     = c;
        end
      end
      exp_ready = '0;
      if (found && outstanding < RSP_DEPTH) exp_ready[w] = 1'b1;
      chk("req_ready", 32'(req_ready), 32'(exp_ready));
      chk("busy", 32'(busy), 32'(outstanding != 0));
      chk("mul_valid", 32'(mul_valid), 32'(prev_hs));
      if (prev_hs) begin
        chk("mul_a", mul_a, prev_a);
        chk("mul_b", mul_b, prev_b);
      end

      exp_rv = (q.size() > 0) && (q[0].avail <= cyc);
      chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
      if (exp_rv && rsp_valid) begin
        chk("rsp_id", 32'(rsp_id), 32'(q[0].id));
        chk("rsp_data", rsp_data, q[0].data);
      end
      if (exp_rv && rsp_ready) begin
        void'(q.pop_front());
        outstanding--;
      end

      prev_hs = (exp_ready != '0);
      if (prev_hs) begin
        prev_a  = req_a[w*32 +: 32];
        prev_b  = req_b[w*32 +: 32];
        e.id    = ID_W'(w);
        e.data  = exp_result(prev_a, prev_b);
        e.avail = cyc + MUL_LAT + 1;
        q.push_back(e);
        outstanding++;
        last = w;
      end
      hs_mask = req_valid & req_ready;
    end
  end

  // Stimulus: requesters hold valid and operands until accepted.
  logic        v [NUM_REQ];
  logic [31:0] oa [NUM_REQ];
  logic [31:0] ob [NUM_REQ];
  int          vprob = 0;
  int          rprob = 100;

  function automatic logic [31:0] rand_op();
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(7) == 0) return {r[31], 31'b0};
    return r;
  endfunction

  task automatic apply();
    for (int i = 0; i < NUM_REQ; i++) begin
      req_valid[i]        = v[i];
      req_a[i*32 +: 32]   = oa[i];
      req_b[i*32 +: 32]   = ob[i];
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (hs_mask[i]) v[i] = 1'b0;
      if (!v[i] && ($urandom_range(99) < vprob)) begin
        v[i]  = 1'b1;
        oa[i] = rand_op();
        ob[i] = rand_op();
      end
    end
    rsp_ready = ($urandom_range(99) < rprob);
    apply();
  endtask

  task automatic directed(input int r, input logic [31:0] a, input logic [31:0] b);
    v[r]  = 1'b1;
    oa[r] = a;
    ob[r] = b;
    apply();
  endtask

  initial begin
    for (int i = 0; i < NUM_REQ; i++) begin
      v[i] = 1'b0; oa[i] = '0; ob[i] = '0;
    end
    rst_n = 1'b0;
    rsp_ready = 1'b0;
    apply();
    repeat (3) step();
    rst_n = 1'b1;

    // Single operation, then a signed-zero operand pair.
    step();
    directed(0, 32'h4000_0000, 32'h4040_0000);
    repeat (8) step();
    directed(1, 32'h8000_0000, 32'h3F80_0000);
    repeat (8) step();

    // Fairness with all requesters saturating.
    vprob = 100; rprob = 100;
    repeat (20) step();
    vprob = 0;
    repeat (10) step();

    // Backpressure, a single-cycle release, then reset with work in flight.
    vprob = 100; rprob = 0;
    repeat (10) step();
    rprob = 100;
    step();
    rprob = 0;
    repeat (4) step();
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    rprob = 100;
    repeat (12) step();

    // Sparse and mixed random traffic.
    vprob = 15; rprob = 80;
    repeat (150) step();
    vprob = 40; rprob = 50;
    repeat (400) step();

    vprob = 0; rprob = 100;
    for (int t = 0; t < 200 && (q.size() != 0 || req_valid != '0); t++) step();
    repeat (3) step();
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d responses outstanding, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fp32_mul_scheduler.md
Name: fp32_mul_scheduler

Overview:
Shares one FP32 multiplier datapath between NUM_REQ requesters. Round-robin arbiter accepts one operand pair per cycle and drives the shared multiplier's operand inputs. A tag pipeline tracks requester IDs through the fixed datapath latency. Results return in issue order through a credit-protected response FIFO, so the fixed-latency datapath never overruns a stalled consumer.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ID_W, 2, width of rsp_id; must be >= clog2(NUM_REQ)
MUL_LAT, 1, cycles from mul_valid to result on mul_res; 1 = combinational multiplier (1..8)
RSP_DEPTH, 4, response FIFO entries and maximum outstanding operations (2..16)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
req_valid  in  NUM_REQ  per-requester operation valid
req_ready  out  NUM_REQ  per-requester accept (one-hot or zero)
req_a  in  NUM_REQ*32  operand A, requester i at [32i+31:32i]
req_b  in  NUM_REQ*32  operand B, same packing
mul_a  out  32  operand A to shared multiplier
mul_b  out  32  operand B to shared multiplier
mul_valid  out  1  operands on mul_a/mul_b are a new issue
mul_res  in  32  multiplier result
rsp_valid  out  1  response available
rsp_ready  in  1  consumer accepts response
rsp_id  out  ID_W  requester index of response
rsp_data  out  32  FP32 product
busy  out  1  any operation in flight or buffered

Behaviour:
- Reset: clk and rst_n only; reset is synchronous, active-low. While rst_n=0 at an edge, all state clears: req_ready=0, mul_valid=0, mul_a=mul_b=0, rsp_valid=0, rsp_id=0, rsp_data=0, busy=0, FIFO empty, credit count 0, RR pointer set so requester 0 has highest priority.
- Reset mid-operation discards in-flight tags and FIFO contents. Nothing issued before reset ever produces a response.
- Credits: cnt = in-flight tags + FIFO occupancy, held in a register.
  - Grant is allowed only when cnt < RSP_DEPTH. The registered cnt is used, so a pop frees a credit for the following cycle.
  - cnt next = cnt + grant - pop.
- Arbitration: round-robin. Search starts at last_grant+1 modulo NUM_REQ. At most one req_ready bit is high, and only for an asserted req_valid.
  - req_ready is combinational from req_valid, the pointer and cnt.
  - Handshake is req_valid[i] & req_ready[i]. The pointer updates to i only on a handshake.
  - A requester must hold req_valid and its operands until accepted.
- Issue: handshake at the edge ending cycle T loads mul_a/mul_b from the winner. mul_valid=1 for cycle T+1 only.
  - With no issue, mul_a/mul_b hold their last values and mul_valid=0.
  - Back-to-back issues in consecutive cycles are supported.
- Tag pipeline: MUL_LAT-stage shift register of {valid, id}. The entry for an issue in cycle C (mul_valid high) samples mul_res at the edge ending cycle C+MUL_LAT-1 and pushes {id, data} into the FIFO.
- Latency: handshake cycle T to rsp_valid is MUL_LAT+1 cycles when the FIFO is empty (T+2 for MUL_LAT=1).
- Response FIFO: RSP_DEPTH entries. rsp_* shows the head entry; pop on rsp_valid & rsp_ready.
  - Simultaneous push and pop is supported at any occupancy, including full-with-pop and empty-with-push.
  - Push into a full FIFO cannot occur by construction of the credit scheme.
  - Read/write pointers wrap modulo RSP_DEPTH.
- Ordering: responses leave strictly in issue order, across all requesters.
- busy = (cnt != 0).
- No FP arithmetic in this block except the optional bypass below.

Optional Feature:
Macro FP_MUL_ZERO_BYPASS_EN.
- Defined: at issue, flag zero if either operand has exp==0 and frac==0. The flag travels with the tag. At capture, a flagged entry stores {a[31]^b[31], 31'b0} instead of mul_res. Latency and ordering are unchanged.
- Undefined: the flag logic is absent and mul_res is always stored.

Test Plan:
1. Single op: MUL_LAT=1; req_valid=4'b0001, a=0x40000000, b=0x40400000; bench multiplier model returns 0x40C00000 -> req_ready[0] in cycle 0, mul_valid in cycle 1, rsp_valid in cycle 2 with rsp_id=0 and rsp_data=0x40C00000.
2. Fairness: all 4 requesters valid continuously, rsp_ready=1, MUL_LAT=3 -> grants 0,1,2,3,0,1... one per cycle; rsp_id sequence identical, starting 4 cycles after the first grant.
3. Backpressure: RSP_DEPTH=4, rsp_ready=0, all valid -> exactly 4 grants, then req_ready=0 and busy=1. Pulse rsp_ready for 1 cycle -> exactly one pop and one new grant the next cycle.
4. Reset mid-flight: assert rst_n=0 with 3 ops outstanding -> rsp_valid never rises for them. After release, with all valid, requester 0 is granted first.
5. RR skip: last_grant=3, only req_valid[2]=1 -> requester 2 granted the same cycle; with req_valid 4'b0101 and last_grant=0 -> requester 2 wins, then requester 0.
6. Zero bypass: a=0x80000000, b=0x3F800000, model returns 0x12345678 -> with FP_MUL_ZERO_BYPASS_EN rsp_data=0x80000000; without it, rsp_data=0x12345678.
